// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that merges ALU and load writebacks into one registered register-file write port.
// Optional macro WB_BYPASS_EN adds forwarding of the staged write onto the register-file read data.
module regfile_wb_arbiter #(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_rd,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  input  logic            stall,
  output logic            RegWrite,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] writeData
`ifdef WB_BYPASS_EN
  ,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [XLEN-1:0] readData1,
  input  logic [XLEN-1:0] readData2,
  output logic [XLEN-1:0] fwdData1,
  output logic [XLEN-1:0] fwdData2
`endif
);

  typedef enum logic {IDLE, WRITE} stateT;

  stateT           state_q, state_d;
  logic            lastGrant_q, lastGrant_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            transfer;
  logic            grant1;
  logic [AW-1:0]   selRd;
  logic [XLEN-1:0] selData;

  // On a conflict the requester that did not win last time is served.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && !stall) begin
      req0_ready = req0_valid && (!req1_valid || lastGrant_q);
      req1_ready = req1_valid && (!req0_valid || !lastGrant_q);
    end
  end

  assign transfer = req0_ready | req1_ready;
  assign grant1   = req1_ready;
  assign selRd    = grant1 ? req1_rd   : req0_rd;
  assign selData  = grant1 ? req1_data : req0_data;

  always_comb begin
    state_d     = IDLE;
    lastGrant_d = lastGrant_q;
    rd_d        = rd_q;
    data_d      = data_q;
    if (transfer) begin
      lastGrant_d = grant1;
      rd_d        = selRd;
      data_d      = selData;
      // Writes to x0 are consumed but never staged.
      if (selRd != '0) state_d = WRITE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      rd_q        <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
    end
  end

  assign RegWrite  = (state_q == WRITE);
  assign rd        = rd_q;
  assign writeData = data_q;

`ifdef WB_BYPASS_EN
  assign fwdData1 = (RegWrite && (rs1 == rd) && (rs1 != '0)) ? writeData : readData1;
  assign fwdData2 = (RegWrite && (rs2 == rd) && (rs2 != '0)) ? writeData : readData2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus queues expected writes, a monitor checks them.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req1_valid, stall;
  logic [AW-1:0]   req0_rd, req1_rd;
  logic [XLEN-1:0] req0_data, req1_data;
  logic            req0_ready, req1_ready;
  logic            RegWrite;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] writeData;
`ifdef WB_BYPASS_EN
  logic [AW-1:0]   rs1, rs2;
  logic [XLEN-1:0] readData1, readData2, fwdData1, fwdData2;
`endif

  typedef struct {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wrT;

  wrT expQ[$];
  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .stall(stall), .RegWrite(RegWrite), .rd(rd), .writeData(writeData)
`ifdef WB_BYPASS_EN
    , .rs1(rs1), .rs2(rs2), .readData1(readData1), .readData2(readData2),
    .fwdData1(fwdData1), .fwdData2(fwdData2)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                             input logic [XLEN-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus; readies and RegWrite are checked against hand-derived values.
  task automatic applyStimulus(input logic v0, input logic [AW-1:0] r0, input logic [XLEN-1:0] d0,
                               input logic v1, input logic [AW-1:0] r1, input logic [XLEN-1:0] d1,
                               input logic st, input logic expR0, input logic expR1,
                               input logic expRw, input string name);
    @(posedge clk);
    #1;
    req0_valid = v0; req0_rd = r0; req0_data = d0;
    req1_valid = v1; req1_rd = r1; req1_data = d1;
    stall = st;
    #3;
    checkOutput({name, ".req0_ready"}, {63'd0, req0_ready}, {63'd0, expR0});
    checkOutput({name, ".req1_ready"}, {63'd0, req1_ready}, {63'd0, expR1});
    checkOutput({name, ".RegWrite"}, {63'd0, RegWrite}, {63'd0, expRw});
    if (expR0 && r0 != '0) expQ.push_back('{rd: r0, data: d0});
    if (expR1 && r1 != '0) expQ.push_back('{rd: r1, data: d1});
  endtask

  task automatic idle(input logic expRw, input string name);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, expRw, name);
  endtask

  task automatic doReset(input string name);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 64'd1;
    req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 64'd2;
    stall = 1'b0;
    expQ.delete();
    #2;
    checkOutput({name, ".req0_ready"}, {63'd0, req0_ready}, 64'd0);
    checkOutput({name, ".req1_ready"}, {63'd0, req1_ready}, 64'd0);
    checkOutput({name, ".RegWrite"}, {63'd0, RegWrite}, 64'd0);
    checkOutput({name, ".rd"}, {59'd0, rd}, 64'd0);
    checkOutput({name, ".writeData"}, writeData, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Every staged write must match the oldest expected transfer.
  always @(negedge clk) begin
    if (!rst && RegWrite) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write: rd=%0d data=%0h with none expected", rd, writeData);
      end else begin
        wrT e;
        e = expQ.pop_front();
        checkOutput("mon.rd", {59'd0, rd}, {59'd0, e.rd});
        checkOutput("mon.writeData", writeData, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b0;
    req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
    req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
    stall = 1'b0;
`ifdef WB_BYPASS_EN
    rs1 = '0; rs2 = '0; readData1 = '0; readData2 = '0;
`endif

    doReset("reset0");

    // Single ALU writeback
    applyStimulus(1, 5'd5, 64'd10, 0, '0, '0, 0, 1, 0, 0, "single");
    idle(1, "single.stage");
    idle(0, "single.done");

    // Both requesters from reset: grants 0,1,0,1
    doReset("reset1");
    applyStimulus(1, 5'd3, 64'd25, 1, 5'd7, 64'd40, 0, 1, 0, 0, "rr0");
    applyStimulus(1, 5'd3, 64'd25, 1, 5'd7, 64'd40, 0, 0, 1, 1, "rr1");
    applyStimulus(1, 5'd3, 64'd25, 1, 5'd7, 64'd40, 0, 1, 0, 1, "rr2");
    applyStimulus(1, 5'd3, 64'd25, 1, 5'd7, 64'd40, 0, 0, 1, 1, "rr3");
    idle(1, "rr.tail");
    idle(0, "rr.done");

    // Write to x0 accepted but not performed; pointer moves to 1
    applyStimulus(0, '0, '0, 1, 5'd0, 64'd99, 0, 0, 1, 0, "x0");
    idle(0, "x0.after");

    // Stall blocks grants; req0 wins on release since pointer is 1
    applyStimulus(1, 5'd3, 64'd25, 1, 5'd7, 64'd40, 1, 0, 0, 0, "stall0");
    applyStimulus(1, 5'd3, 64'd25, 1, 5'd7, 64'd40, 1, 0, 0, 0, "stall1");
    applyStimulus(1, 5'd3, 64'd25, 1, 5'd7, 64'd40, 1, 0, 0, 0, "stall2");
    applyStimulus(1, 5'd3, 64'd25, 1, 5'd7, 64'd40, 0, 1, 0, 0, "release");
    idle(1, "release.stage");
    idle(0, "release.done");

    // A staged write completes under stall; pointer held at 0
    applyStimulus(1, 5'd4, 64'h44, 0, '0, '0, 0, 1, 0, 0, "stallw");
    applyStimulus(1, 5'd3, 64'd25, 1, 5'd7, 64'd40, 1, 0, 0, 1, "stallw.hold");
    applyStimulus(1, 5'd3, 64'd25, 1, 5'd7, 64'd40, 1, 0, 0, 0, "stallw.hold2");
    applyStimulus(1, 5'd3, 64'd25, 1, 5'd7, 64'd40, 0, 0, 1, 0, "stallw.release");
    idle(1, "stallw.stage");
    idle(0, "stallw.done");

`ifdef WB_BYPASS_EN
    applyStimulus(1, 5'd5, 64'd10, 0, '0, '0, 0, 1, 0, 0, "byp");
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    rs1 = 5'd5; readData1 = 64'd0;
    rs2 = 5'd0; readData2 = 64'd123;
    #2;
    checkOutput("byp.fwdData1", fwdData1, 64'd10);
    checkOutput("byp.fwdData2", fwdData2, 64'd123);
    rs1 = 5'd6; readData1 = 64'd77;
    #1;
    checkOutput("byp.fwdData1.miss", fwdData1, 64'd77);
    idle(0, "byp.done");
    rs1 = 5'd5; readData1 = 64'd55;
    #1;
    checkOutput("byp.fwdData1.idle", fwdData1, 64'd55);
`endif

    // Reset right after a transfer discards the staged write
    doReset("reset2");
    applyStimulus(1, 5'd9, 64'd77, 0, '0, '0, 0, 1, 0, 0, "rstw");
    @(posedge clk);
    #1;
    rst = 1'b1;
    req0_valid = 1'b0;
    expQ.delete();
    #2;
    checkOutput("rstw.RegWrite", {63'd0, RegWrite}, 64'd0);
    checkOutput("rstw.rd", {59'd0, rd}, 64'd0);
    checkOutput("rstw.writeData", writeData, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(0, "rstw.after0");
    idle(0, "rstw.after1");
    checkOutput("rstw.rd.after", {59'd0, rd}, 64'd0);
    checkOutput("rstw.writeData.after", writeData, 64'd0);

    @(posedge clk);
    #4;
    checkOutput("queue.leftover", 64'(expQ.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameters SHALL be: XLEN, 64, data width; AW, 5, register address width (32 registers).
REQ-002 Clock and reset SHALL be one clock and an asynchronous, active-high reset: clk input 1 is the clock (all state on posedge); rst input 1 is the asynchronous, active-high reset.
REQ-003 Ports SHALL be, in order after clk/rst:
- req0_valid in 1: ALU writeback request
- req0_rd in AW: destination register
- req0_data in XLEN: write data
- req0_ready out 1: req0 accepted this cycle
- req1_valid, req1_rd, req1_data, req1_ready: load writeback, same widths and meaning
- stall in 1: blocks all grants
- RegWrite out 1: register-file write enable
- rd out AW: register-file write address
- writeData out XLEN: register-file write data
- rs1, rs2 in AW: register-file read addresses (present only with WB_BYPASS_EN)
- readData1, readData2 in XLEN: register-file read data (present only with WB_BYPASS_EN)
- fwdData1, fwdData2 out XLEN: bypassed read data (present only with WB_BYPASS_EN)

Function
REQ-004 A transfer SHALL occur on a posedge where reqN_valid and reqN_ready are both 1; at most one transfer SHALL occur per cycle.
REQ-005 reqN_ready SHALL be combinational: 0 when stall=1 or reqN_valid=0; otherwise 1 if reqN is the only valid requester or holds priority.
REQ-006 Priority SHALL be round-robin: the 1-bit pointer last_grant SHALL update to the granted index on each transfer; when both are valid, the requester not equal to last_grant wins.
REQ-007 A requester SHALL hold valid, rd and data stable until accepted; the arbiter does not check this.
REQ-008 The output stage SHALL be registered: a transfer at edge T drives rd/writeData from edge T and RegWrite=1 for exactly the cycle T..T+1; the register file commits at edge T+1.
REQ-009 A cycle without a transfer SHALL drive RegWrite=0; rd/writeData SHALL hold their previous values.
REQ-010 A transfer with rd=0 SHALL be accepted (ready=1) and SHALL update the pointer, but SHALL drive RegWrite=0.
REQ-011 The control state machine SHALL have states IDLE (no write staged) and WRITE (write staged); IDLE->WRITE on transfer with rd!=0; WRITE->WRITE on such a transfer; WRITE->IDLE otherwise; RegWrite = (state==WRITE).
REQ-012 Sustained back-to-back requests on both ports SHALL alternate grants 0,1,0,1 with one write per cycle.
REQ-013 stall=1 SHALL hold pointer and deassert both readies; a staged write already in WRITE SHALL still complete.

Reset
REQ-014 rst=1 SHALL force, asynchronously: state=IDLE, RegWrite=0, rd=0, writeData=0, last_grant=1 (req0 wins the first conflict).
REQ-015 A reset asserted while in WRITE SHALL discard the staged write: no RegWrite pulse after rst deasserts.
REQ-016 reqN_ready SHALL be 0 while rst=1.

Configuration
REQ-017 Macro WB_BYPASS_EN SHALL, when defined, add the bypass ports: fwdDataK = writeData if RegWrite=1 and rsK==rd and rsK!=0, else readDataK (combinational).
REQ-018 Without WB_BYPASS_EN, the bypass ports and bypass logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-019 Reset, then req0 valid rd=5 data=10 alone -> req0_ready=1; next cycle RegWrite=1, rd=5, writeData=10; the following cycle RegWrite=0.
REQ-020 Both valid from reset (req0 rd=3 data=25, req1 rd=7 data=40) held 4 cycles -> grant order 0,1,0,1; RegWrite high 4 consecutive cycles.
REQ-021 req1 valid rd=0 data=99 -> req1_ready=1, RegWrite stays 0, pointer=1.
REQ-022 stall=1 with both valid for 3 cycles -> both ready=0, no RegWrite; stall released -> the round-robin winner is granted first.
REQ-023 rst pulsed the cycle after a transfer to rd=9 -> RegWrite=0 throughout and after reset; rd=0, writeData=0.
REQ-024 With WB_BYPASS_EN: staged write rd=5 data=10, rs1=5, readData1=0 -> fwdData1=10; rs2=0 -> fwdData2=readData2.
